// File: rtl/multicycle_cpu_core.sv
// Multi-cycle MIPS-subset core: one shared ALU, one unified memory port.
// FETCH/DECODE/EXEC/MEM/WB sequencing with req/ready memory handshake.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mem_req/mem_we    request valid / write strobe (both 0 while rst)
//   mem_addr          byte address (low ADDR_W bits)
//   mem_wdata         store data
//   mem_rdata         read data, valid while mem_ready=1
//   mem_ready         completes the transaction at the edge with mem_req
//   halted            core parked in HALT
//   fault             0 none, 1 illegal op/funct, 2 misaligned lw/sw
//   retired           completed-instruction counter (wraps)
//   dbg_pc            current PC register
module multicycle_cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [1:0]        fault,
  output logic [CNT_W-1:0]  retired,
  output logic [31:0]       dbg_pc
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [1:0] fault_q, fault_d;
  logic [31:0] regs_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] simm;
  logic [25:0] tgt;
  logic        unused_shamt;

  assign op           = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign simm         = {{16{ir_q[15]}}, ir_q[15:0]};
  assign tgt          = ir_q[25:0];
  assign unused_shamt = ^ir_q[10:6];

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_j;
  logic r_ok, legal;
  alu_op_e r_op;

  assign is_r    = (op == OP_R);
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);

  always_comb begin
    r_ok = 1'b1;
    r_op = ALU_ADD;
    unique case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_SLT:  r_op = ALU_SLT;
      default: r_ok = 1'b0;
    endcase
  end

  assign legal = (is_r & r_ok) | is_addi | is_lw
               | is_sw | is_beq | is_j;

  // Shared ALU: PC+4 in FETCH, branch target in DECODE,
  // operation / address / compare in EXEC.
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_e     alu_op;

  always_comb begin
    alu_a  = pc_q;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    unique case (state_q)
      S_DECODE: alu_b = simm << 2;
      S_EXEC: begin
        alu_a = a_q;
        if (is_r) begin
          alu_b  = b_q;
          alu_op = r_op;
        end else if (is_beq) begin
          alu_b  = b_q;
          alu_op = ALU_SUB;
        end else begin
          alu_b = simm;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_y = 32'd0;
    unique case (alu_op)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = 32'd0;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = alu_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = alu_y;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = regs_q[rs];
        b_d   = regs_q[rt];
        alu_d = alu_y;
        if (!legal) begin
          fault_d = 2'd1;
          state_d = S_HALT;
        end else if (is_j) begin
          pc_d      = {pc_q[31:28], tgt, 2'b00};
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          // alu_y is A-B here; ALUOut still holds the target
          if (alu_y == 32'd0) pc_d = alu_q;
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else begin
          alu_d = alu_y;
          if ((is_lw | is_sw) && (alu_y[1:0] != 2'b00)) begin
            fault_d = 2'd2;
            state_d = S_HALT;
          end else if (is_lw | is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_sw) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_waddr  = is_r ? rd : rt;
        rf_wdata  = is_lw ? mdr_q : alu_q;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_q     <= 32'd0;
      mdr_q     <= 32'd0;
      retired_q <= '0;
      fault_q   <= 2'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      // $0 is never written, so it reads as zero
      if (rf_we && (rf_waddr != 5'd0)) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Memory port; request is squashed combinationally during reset
  logic [31:0] addr_full;

  assign addr_full = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign mem_req   = !rst && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = !rst && (state_q == S_MEM) && is_sw;

  assign halted  = !rst && (state_q == S_HALT);
  assign fault   = fault_q;
  assign retired = retired_q;
  assign dbg_pc  = pc_q;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core with a wait-state memory model.
// Checks reset, ALU ops, loads/stores, branches, faults, reset abort.
module tb_multicycle_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] retired, dbg_pc;

  multicycle_cpu_core #(
    .RESET_PC(32'h0000_0100),
    .ADDR_W(32),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .halted(halted),
    .fault(fault),
    .retired(retired),
    .dbg_pc(dbg_pc)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: 1 KB, wait_n wait cycles before ready
  logic [31:0] mem [256];
  int          wait_n = 0;
  int          cnt = 0;
  logic [31:0] fetch_q [$];
  logic [64:0] lat;

  assign mem_ready = mem_req && (cnt == wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      else fetch_q.push_back(mem_addr);
      cnt <= 0;
    end else if (mem_req) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (mem_req) begin
      if (cnt == 0) lat = {mem_addr, mem_we, mem_wdata};
      else chk("req_stable", {mem_addr, mem_we, mem_wdata}, lat);
    end
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [31:0] addr);
    return {6'b000010, addr[27:2]};
  endfunction

  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;

  task automatic begin_reset(input int w);
    @(negedge clk);
    rst = 1'b1;
    wait_n = w;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    fetch_q.delete();
  endtask

  task automatic end_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_retired(input string tag, input logic [31:0] n);
    int k = 0;
    while (retired < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, retired, n);
  endtask

  logic [31:0] exp_f [9];
  int nreq;
  int k;

  initial begin
    // Test 1/2 program, loaded while reset is held from time 0
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = i_ins(ADDI, 0, 1, 16'd5);
    mem[8'h41] = i_ins(ADDI, 0, 2, 16'hFFFD);
    mem[8'h42] = r_ins(1, 2, 3, 6'b100000);
    mem[8'h43] = r_ins(2, 1, 4, 6'b101010);
    mem[8'h44] = r_ins(1, 2, 6, 6'b100010);
    mem[8'h45] = r_ins(1, 2, 7, 6'b100100);
    mem[8'h46] = r_ins(1, 2, 8, 6'b100101);
    mem[8'h47] = r_ins(1, 2, 9, 6'b101010);
    mem[8'h48] = i_ins(SW, 0, 3, 16'h0200);
    mem[8'h49] = i_ins(SW, 0, 4, 16'h0204);
    mem[8'h4A] = i_ins(SW, 0, 6, 16'h0208);
    mem[8'h4B] = i_ins(SW, 0, 7, 16'h020C);
    mem[8'h4C] = i_ins(SW, 0, 8, 16'h0210);
    mem[8'h4D] = i_ins(SW, 0, 9, 16'h0214);
    mem[8'h4E] = r_ins(1, 1, 0, 6'b100000);
    mem[8'h4F] = i_ins(SW, 0, 0, 16'h0218);
    mem[8'h50] = j_ins(32'h140);
    mem[8'h86] = 32'hDEAD_BEEF;

    @(negedge clk);
    chk("t1_rst_req", mem_req, 1'b0);
    chk("t1_rst_we", mem_we, 1'b0);
    chk("t1_rst_halt", halted, 1'b0);
    end_reset();
    #1;
    chk("t1_req", mem_req, 1'b1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_retired", retired, 32'd0);
    chk("t1_fault", fault, 2'd0);
    chk("t1_pc", dbg_pc, 32'h100);

    // Test 2: ALU ops, zero-wait timing
    run(16);
    chk("t2_ret16", retired, 32'd4);
    chk("t2_pc16", dbg_pc, 32'h110);
    wait_retired("t2_done", 32'd17);
    chk("t2_add", mem[8'h80], 32'd2);
    chk("t2_slt1", mem[8'h81], 32'd1);
    chk("t2_sub", mem[8'h82], 32'd8);
    chk("t2_and", mem[8'h83], 32'd5);
    chk("t2_or", mem[8'h84], 32'hFFFF_FFFD);
    chk("t2_slt0", mem[8'h85], 32'd0);
    chk("t2_r0", mem[8'h86], 32'd0);

    // Test 3: sw/lw with 3 wait cycles per access
    begin_reset(3);
    mem[0]     = 32'h0000_AAAA;
    mem[3]     = 32'h0000_BBBB;
    mem[8'h40] = i_ins(ADDI, 0, 3, 16'd2);
    mem[8'h41] = i_ins(SW, 0, 3, 16'd8);
    mem[8'h42] = i_ins(LW, 0, 5, 16'd8);
    mem[8'h43] = i_ins(SW, 0, 5, 16'd12);
    mem[8'h44] = j_ins(32'h110);
    end_reset();
    run(16);
    chk("t3_ret16", retired, 32'd1);
    run(1);
    chk("t3_ret17", retired, 32'd2);
    chk("t3_sw", mem[2], 32'd2);
    run(10);
    chk("t3_ret27", retired, 32'd2);
    run(1);
    chk("t3_ret28", retired, 32'd3);
    wait_retired("t3_done", 32'd4);
    chk("t3_lw", mem[3], 32'd2);

    // Test 4: beq taken/not-taken and j
    begin_reset(0);
    mem[8'h40] = j_ins(32'h10);
    mem[4]     = i_ins(BEQ, 0, 1, 16'hFFFC);
    mem[1]     = i_ins(ADDI, 0, 1, 16'd7);
    mem[2]     = i_ins(ADDI, 0, 2, 16'd0);
    mem[3]     = i_ins(ADDI, 0, 2, 16'd0);
    mem[5]     = j_ins(32'h40);
    mem[8'h10] = j_ins(32'h40);
    end_reset();
    exp_f = '{32'h100, 32'h10, 32'h04, 32'h08, 32'h0C,
              32'h10, 32'h14, 32'h40, 32'h40};
    k = 0;
    while (fetch_q.size() < 9 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (fetch_q.size() < 9) begin
      chk("t4_fetch_cnt", fetch_q.size(), 9);
    end else begin
      for (int i = 0; i < 9; i++)
        chk($sformatf("t4_fetch%0d", i), fetch_q[i], exp_f[i]);
    end

    // Test 5a: illegal opcode
    begin_reset(0);
    mem[8'h40] = 32'hFC00_0000;
    end_reset();
    run(2);
    chk("t5_halt", halted, 1'b1);
    chk("t5_fault", fault, 2'd1);
    chk("t5_ret", retired, 32'd0);
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) nreq++;
    end
    chk("t5_quiet", nreq, 0);
    chk("t5_halt_hold", halted, 1'b1);

    // Test 5b: illegal funct
    begin_reset(0);
    mem[8'h40] = r_ins(1, 2, 3, 6'b000000);
    end_reset();
    run(2);
    chk("t5b_fault", fault, 2'd1);

    // Test 5c: misaligned lw
    begin_reset(0);
    mem[8'h40] = i_ins(LW, 0, 5, 16'd6);
    end_reset();
    chk("t5c_clr", fault, 2'd0);
    run(2);
    chk("t5c_early", halted, 1'b0);
    run(1);
    chk("t5c_fault", fault, 2'd2);
    chk("t5c_halt", halted, 1'b1);
    chk("t5c_req", mem_req, 1'b0);

    // Test 6: reset during a waiting store
    begin_reset(3);
    mem[8'h40] = i_ins(ADDI, 0, 3, 16'd9);
    mem[8'h41] = i_ins(SW, 0, 3, 16'h0020);
    mem[8]     = 32'h1234_5678;
    end_reset();
    k = 0;
    while (!(mem_req && mem_we) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reach_sw", mem_req && mem_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_req0", mem_req, 1'b0);
    chk("t6_we0", mem_we, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_nowrite", mem[8], 32'h1234_5678);
    chk("t6_ret", retired, 32'd0);
    chk("t6_addr", mem_addr, 32'h100);
    chk("t6_pc", dbg_pc, 32'h100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
